pool_engine: RTL and testbench

- Parametrised pooling layer engine following the convolution stage of the CONV pipeline.
- Reads a convolved feature map from the shared layer memory through the crd/caddr_rd/cdata_rd port and reduces each non-overlapping POOL x POOL window to one value.
- The reduction is max or average, selected at run time.
- Writes the result map back through cwr/caddr_wr/cdata_wr, using the same ready/busy start handshake and csel bank select as the conv engine.

---
 rtl/pool_engine.sv | 180 ++++++++++++++++++
 tb/tb_pool_engine.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_engine.sv
// -----------------------------------------------------------------------------
// pool_engine
//   Pooling stage that runs after the convolution engine. It reads a feature
//   map from the shared layer memory and reduces each non-overlapping
//   POOL x POOL window to a single pixel, either by signed max or by signed
//   floor-average. The reduced map is written back to the same memory.
//   Reads and writes share one csel bank select, so they never overlap.
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset     in   synchronous active-low reset
//   ready     in   start request, sampled only in IDLE
//   mode      in   0 = max, 1 = average, latched at start
//   busy      out  high while a map is being processed
//   crd       out  read strobe
//   caddr_rd  out  read address
//   cdata_rd  in   read data, valid one cycle after crd/caddr_rd
//   cwr       out  write strobe
//   caddr_wr  out  write address
//   cdata_wr  out  write data
//   csel      out  memory bank select (SRC_SEL on reads, DST_SEL on writes)
// -----------------------------------------------------------------------------
module pool_engine #(
    parameter int   IMG_W   = 64,
    parameter int   IMG_H   = 64,
    parameter int   POOL    = 2,
    parameter int   DW      = 13,
    parameter int   AW      = 12,
    parameter logic SRC_SEL = 1'b0,
    parameter logic DST_SEL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic          mode,
    output logic          busy,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic          csel
);

    localparam int OW  = IMG_W / POOL;
    localparam int OH  = IMG_H / POOL;
    localparam int NK  = POOL * POOL;
    localparam int XW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int YW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int KW  = $clog2(NK);
    localparam int SH  = 2 * $clog2(POOL);
    localparam int ACW = DW + SH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAST,
        S_WR,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_mode;
    logic [XW-1:0]         r_ox;
    logic [YW-1:0]         r_oy;
    logic [KW-1:0]         r_k;
    logic signed [ACW-1:0] r_acc;
    logic [AW-1:0]         r_caddr_rd;
    logic [AW-1:0]         r_caddr_wr;
    logic [DW-1:0]         r_cdata_wr;
    logic                  r_csel;

    logic [AW-1:0]         w_rd_addr;
    logic [AW-1:0]         w_wr_addr;
    logic signed [ACW-1:0] w_data_ext;
    logic signed [ACW-1:0] w_acc_next;
    logic [DW-1:0]         w_result;
    logic                  w_last_out;

    assign w_rd_addr  = AW'((int'(r_oy) * POOL + int'(r_k) / POOL) * IMG_W
                            + int'(r_ox) * POOL + int'(r_k) % POOL);
    assign w_wr_addr  = AW'(int'(r_oy) * OW + int'(r_ox));
    assign w_data_ext = {{SH{cdata_rd[DW-1]}}, cdata_rd};
    assign w_last_out = (r_ox == XW'(OW - 1)) && (r_oy == YW'(OH - 1));

    // Average: the slice above the SH fraction bits is the arithmetic shift,
    // i.e. floor toward negative infinity. Max: the accumulator already holds
    // a sign-extended pixel.
    assign w_result = r_mode ? r_acc[ACW-1:SH] : r_acc[DW-1:0];

    // Element k-1 arrives while element k is being requested, so element 0
    // is on cdata_rd when r_k == 1; that one seeds the accumulator.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        w_acc_next = r_acc;
        if (r_state == S_RD && r_k == KW'(1)) begin
            w_acc_next = w_data_ext;
        end else if (r_mode) begin
            w_acc_next = r_acc + w_data_ext;
        end else if (w_data_ext > r_acc) begin
            w_acc_next = w_data_ext;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (ready) w_next_state = S_RD;
            S_RD:    if (r_k == KW'(NK - 1)) w_next_state = S_LAST;
            S_LAST:  w_next_state = S_WR;
            S_WR:    w_next_state = w_last_out ? S_DONE : S_RD;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_caddr_rd <= '0;
            r_caddr_wr <= '0;
            r_cdata_wr <= '0;
            r_csel     <= SRC_SEL;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_mode <= mode;
                        r_ox   <= '0;
                        r_oy   <= '0;
                        r_k    <= '0;
                    end
                end
                S_RD: begin
                    r_caddr_rd <= w_rd_addr;
                    r_csel     <= SRC_SEL;
                    if (r_k != '0) r_acc <= w_acc_next;
                    // Wraps to 0 after the last element, ready for the next window.
                    r_k <= r_k + 1'b1;
                end
                S_LAST: begin
                    r_acc <= w_acc_next;
                end
                S_WR: begin
                    r_caddr_wr <= w_wr_addr;
                    r_cdata_wr <= w_result;
                    r_csel     <= DST_SEL;
                    if (r_ox == XW'(OW - 1)) begin
                        r_ox <= '0;
                        r_oy <= r_oy + 1'b1;
                    end else begin
                        r_ox <= r_ox + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by reset so an abort stops memory traffic in the
    // very cycle reset is asserted, not one edge later.
    assign busy     = (r_state == S_RD) || (r_state == S_LAST) || (r_state == S_WR);
    assign crd      = (r_state == S_RD) && reset;
    assign cwr      = (r_state == S_WR) && reset;
    assign caddr_rd = (r_state == S_RD) ? w_rd_addr : r_caddr_rd;
    assign caddr_wr = (r_state == S_WR) ? w_wr_addr : r_caddr_wr;
    assign cdata_wr = (r_state == S_WR) ? w_result  : r_cdata_wr;
    assign csel     = (r_state == S_RD) ? SRC_SEL :
                      (r_state == S_WR) ? DST_SEL : r_csel;

endmodule

// File: tb/tb_pool_engine.sv
// -----------------------------------------------------------------------------
// tb_pool_engine
//   Directed bench for pool_engine. Instance u_a uses the default 64x64,
//   POOL=2 configuration; instance u_b uses 16x16, POOL=4. Each instance has
//   a read-only source memory model and a negedge logger that records every
//   read address and every write (address, data, cycle).
// -----------------------------------------------------------------------------
module tb_pool_engine;
    localparam int DW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0;

    logic          ready_a = 1'b0, mode_a = 1'b0;
    logic          busy_a, crd_a, cwr_a, csel_a;
    logic [11:0]   caddr_rd_a, caddr_wr_a;
    logic [DW-1:0] cdata_rd_a = '0;
    logic [DW-1:0] cdata_wr_a;

    logic          ready_b = 1'b0, mode_b = 1'b0;
    logic          busy_b, crd_b, cwr_b, csel_b;
    logic [7:0]    caddr_rd_b, caddr_wr_b;
    logic [DW-1:0] cdata_rd_b = '0;
    logic [DW-1:0] cdata_wr_b;

    pool_engine u_a (
        .clk(clk), .reset(reset), .ready(ready_a), .mode(mode_a), .busy(busy_a),
        .crd(crd_a), .caddr_rd(caddr_rd_a), .cdata_rd(cdata_rd_a),
        .cwr(cwr_a), .caddr_wr(caddr_wr_a), .cdata_wr(cdata_wr_a), .csel(csel_a)
    );

    pool_engine #(.IMG_W(16), .IMG_H(16), .POOL(4), .AW(8)) u_b (
        .clk(clk), .reset(reset), .ready(ready_b), .mode(mode_b), .busy(busy_b),
        .crd(crd_b), .caddr_rd(caddr_rd_b), .cdata_rd(cdata_rd_b),
        .cwr(cwr_b), .caddr_wr(caddr_wr_b), .cdata_wr(cdata_wr_b), .csel(csel_b)
    );

    logic [DW-1:0] src_a [4096];
    logic [DW-1:0] src_b [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int csel_bad_a = 0, csel_bad_b = 0, overlap_a = 0, overlap_b = 0;
    int            rd_q_a[$], wr_q_a[$], wc_q_a[$];
    logic [DW-1:0] wd_q_a[$];
    int            rd_q_b[$], wr_q_b[$], wc_q_b[$];
    logic [DW-1:0] wd_q_b[$];
    int rb_a, wb_a, cb_a, ob_a, rb_b, wb_b, cb_b;

    // Registered read port: address captured at posedge, data valid next cycle.
    always @(posedge clk) begin
        if (crd_a) cdata_rd_a <= src_a[caddr_rd_a];
        if (crd_b) cdata_rd_b <= src_b[caddr_rd_b];
    end

    always @(negedge clk) begin
        cyc++;
        if (crd_a) begin
            rd_q_a.push_back(int'(caddr_rd_a));
            if (csel_a !== 1'b0) csel_bad_a++;
        end
        if (cwr_a) begin
            wr_q_a.push_back(int'(caddr_wr_a));
            wd_q_a.push_back(cdata_wr_a);
            wc_q_a.push_back(cyc);
            if (csel_a !== 1'b1) csel_bad_a++;
        end
        if (crd_a && cwr_a) overlap_a++;
        if (crd_b) begin
            rd_q_b.push_back(int'(caddr_rd_b));
            if (csel_b !== 1'b0) csel_bad_b++;
        end
        if (cwr_b) begin
            wr_q_b.push_back(int'(caddr_wr_b));
            wd_q_b.push_back(cdata_wr_b);
            wc_q_b.push_back(cyc);
            if (csel_b !== 1'b1) csel_bad_b++;
        end
        if (crd_b && cwr_b) overlap_b++;
    end

    // Reference reduction over n window values.
    function automatic logic [DW-1:0] reduce_win(input int v[16], input int n, input bit md);
        int acc, q;
        acc = v[0];
        for (int i = 1; i < n; i++) begin
            if (md) acc += v[i];
            else if (v[i] > acc) acc = v[i];
        end
        if (md) begin
            q = acc / n;
            if ((acc % n) != 0 && acc < 0) q -= 1;
            acc = q;
        end
        return acc[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] gold_a(input int ox, input int oy, input bit md);
        int v[16];
        for (int i = 0; i < 16; i++) v[i] = 0;
        for (int k = 0; k < 4; k++)
            v[k] = int'($signed(src_a[(oy * 2 + k / 2) * 64 + ox * 2 + k % 2]));
        return reduce_win(v, 4, md);
    endfunction

    function automatic logic [DW-1:0] gold_b(input int ox, input int oy, input bit md);
        int v[16];
        for (int k = 0; k < 16; k++)
            v[k] = int'($signed(src_b[(oy * 4 + k / 4) * 16 + ox * 4 + k % 4]));
        return reduce_win(v, 16, md);
    endfunction

    // Number of logged writes of the latest run that differ from the golden map.
    function automatic int map_bad_a(input bit md);
        int bad = 0;
        if (wr_q_a.size() < wb_a + 1024) return -1;
        for (int o = 0; o < 1024; o++)
            if (wr_q_a[wb_a + o] != o || wd_q_a[wb_a + o] !== gold_a(o % 32, o / 32, md)) bad++;
        return bad;
    endfunction

    function automatic int map_bad_b(input bit md);
        int bad = 0;
        if (wr_q_b.size() < wb_b + 16) return -1;
        for (int o = 0; o < 16; o++)
            if (wr_q_b[wb_b + o] != o || wd_q_b[wb_b + o] !== gold_b(o % 4, o / 4, md)) bad++;
        return bad;
    endfunction

    task automatic set_win_a(input int base, input int p0, input int p1, input int p2, input int p3);
        src_a[base]      = p0[DW-1:0];
        src_a[base + 1]  = p1[DW-1:0];
        src_a[base + 64] = p2[DW-1:0];
        src_a[base + 65] = p3[DW-1:0];
    endtask

    task automatic run_a(input bit md, input bit hold_ready, output int busy_cycles);
        bit seen = 0, done = 0;
        rb_a = rd_q_a.size(); wb_a = wr_q_a.size(); cb_a = csel_bad_a; ob_a = overlap_a;
        busy_cycles = 0;
        @(negedge clk); mode_a = md; ready_a = 1'b1;
        @(negedge clk); if (!hold_ready) ready_a = 1'b0; mode_a = ~md;
        for (int i = 0; i < 8000 && !done; i++) begin
            if (busy_a) begin seen = 1; busy_cycles++; end
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        ready_a = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL run_a_timeout: busy_cycles=%0d, busy never fell", busy_cycles); end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_b(input bit md, output int busy_cycles);
        bit seen = 0, done = 0;
        rb_b = rd_q_b.size(); wb_b = wr_q_b.size(); cb_b = csel_bad_b;
        busy_cycles = 0;
        @(negedge clk); mode_b = md; ready_b = 1'b1;
        @(negedge clk); ready_b = 1'b0; mode_b = ~md;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (busy_b) begin seen = 1; busy_cycles++; end
            else if (seen) done = 1;
            if (!done) @(negedge clk);
        end
        checks++;
        if (!done) begin errors++; $display("FAIL run_b_timeout: busy_cycles=%0d, busy never fell", busy_cycles); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [39:0] obs_a;
        logic [35:0] obs_b;
        reset = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs_a = {busy_a, crd_a, cwr_a, csel_a, caddr_rd_a, caddr_wr_a, cdata_wr_a};
            obs_b = {busy_b, crd_b, cwr_b, csel_b, caddr_rd_b, caddr_wr_b, cdata_wr_b};
            checks++;
            if (obs_a !== '0) begin errors++; $display("FAIL reset_outputs_a cycle %0d: got %h expected 0", i, obs_a); end
            checks++;
            if (obs_b !== '0) begin errors++; $display("FAIL reset_outputs_b cycle %0d: got %h expected 0", i, obs_b); end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++; $display("FAIL reset_release_busy: got a=%b b=%b expected 1 1", busy_a, busy_b);
        end
        ready_a = 1'b0; ready_b = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || cwr_a !== 1'b0) begin
            errors++; $display("FAIL reset_abort_start: got busy=%b cwr=%b expected 0 0", busy_a, cwr_a);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max_default();
        int bc, bad;
        for (int i = 0; i < 4096; i++) src_a[i] = DW'($urandom);
        set_win_a(0, 5, -3, 12, 7);
        set_win_a(2, 1, 2, 3, 4);
        set_win_a(4, -1, -2, -3, -4);
        set_win_a(6, -8, -1, -5, -2);
        set_win_a(8, 7, 7, 7, 7);
        set_win_a(10, 4095, 4095, 4095, 4094);
        set_win_a(12, -4096, -4096, -4096, -4096);
        run_a(1'b0, 1'b0, bc);
        checks++; if (bc !== 6144) begin errors++; $display("FAIL max_busy_cycles: got %0d expected 6144", bc); end
        checks++; if (wr_q_a.size() - wb_a !== 1024) begin errors++; $display("FAIL max_write_count: got %0d expected 1024", wr_q_a.size() - wb_a); end
        checks++; if (rd_q_a.size() - rb_a !== 4096) begin errors++; $display("FAIL max_read_count: got %0d expected 4096", rd_q_a.size() - rb_a); end
        checks++;
        if (rd_q_a[rb_a] !== 0 || rd_q_a[rb_a + 1] !== 1 || rd_q_a[rb_a + 2] !== 64 || rd_q_a[rb_a + 3] !== 65) begin
            errors++; $display("FAIL max_first_reads: got %0d %0d %0d %0d expected 0 1 64 65",
                               rd_q_a[rb_a], rd_q_a[rb_a + 1], rd_q_a[rb_a + 2], rd_q_a[rb_a + 3]);
        end
        checks++; if (wr_q_a[wb_a] !== 0 || wd_q_a[wb_a] !== 13'd12) begin errors++; $display("FAIL max_first_write: got addr %0d data %h expected addr 0 data 00c", wr_q_a[wb_a], wd_q_a[wb_a]); end
        checks++; if (wc_q_a[wb_a + 1] - wc_q_a[wb_a] !== 6) begin errors++; $display("FAIL max_output_period: got %0d expected 6", wc_q_a[wb_a + 1] - wc_q_a[wb_a]); end
        checks++; if (wr_q_a[wb_a + 1023] !== 1023) begin errors++; $display("FAIL max_last_write_addr: got %0d expected 1023", wr_q_a[wb_a + 1023]); end
        checks++; if (wd_q_a[wb_a + 1] !== 13'd4) begin errors++; $display("FAIL max_win_1234: got %h expected 004", wd_q_a[wb_a + 1]); end
        checks++; if (wd_q_a[wb_a + 2] !== 13'h1FFF) begin errors++; $display("FAIL max_win_neg_seq: got %h expected 1fff", wd_q_a[wb_a + 2]); end
        checks++; if (wd_q_a[wb_a + 3] !== 13'h1FFF) begin errors++; $display("FAIL max_all_negative: got %h expected 1fff", wd_q_a[wb_a + 3]); end
        checks++; if (wd_q_a[wb_a + 4] !== 13'd7) begin errors++; $display("FAIL max_equal_values: got %h expected 007", wd_q_a[wb_a + 4]); end
        checks++; if (wd_q_a[wb_a + 5] !== 13'h0FFF) begin errors++; $display("FAIL max_top_value: got %h expected 0fff", wd_q_a[wb_a + 5]); end
        checks++; if (wd_q_a[wb_a + 6] !== 13'h1000) begin errors++; $display("FAIL max_bottom_value: got %h expected 1000", wd_q_a[wb_a + 6]); end
        bad = map_bad_a(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL max_full_map: got %0d bad outputs expected 0", bad); end
        checks++; if (csel_bad_a - cb_a !== 0 || overlap_a - ob_a !== 0) begin
            errors++; $display("FAIL max_csel_overlap: got csel_bad=%0d overlap=%0d expected 0 0", csel_bad_a - cb_a, overlap_a - ob_a);
        end
    endtask

    task automatic test_average();
        int bc, bad;
        // ready is held high through the whole run; it must not restart anything.
        run_a(1'b1, 1'b1, bc);
        checks++; if (bc !== 6144) begin errors++; $display("FAIL avg_busy_cycles: got %0d expected 6144", bc); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL avg_no_restart: got busy %b expected 0", busy_a); end
        checks++; if (wd_q_a[wb_a] !== 13'd5) begin errors++; $display("FAIL avg_win_first: got %h expected 005", wd_q_a[wb_a]); end
        checks++; if (wd_q_a[wb_a + 1] !== 13'd2) begin errors++; $display("FAIL avg_win_1234: got %h expected 002", wd_q_a[wb_a + 1]); end
        checks++; if (wd_q_a[wb_a + 2] !== 13'h1FFD) begin errors++; $display("FAIL avg_floor_negative: got %h expected 1ffd", wd_q_a[wb_a + 2]); end
        checks++; if (wd_q_a[wb_a + 3] !== 13'h1FFC) begin errors++; $display("FAIL avg_exact_negative: got %h expected 1ffc", wd_q_a[wb_a + 3]); end
        checks++; if (wd_q_a[wb_a + 5] !== 13'h0FFE) begin errors++; $display("FAIL avg_top_value: got %h expected 0ffe", wd_q_a[wb_a + 5]); end
        checks++; if (wd_q_a[wb_a + 6] !== 13'h1000) begin errors++; $display("FAIL avg_bottom_value: got %h expected 1000", wd_q_a[wb_a + 6]); end
        bad = map_bad_a(1'b1);
        checks++; if (bad !== 0) begin errors++; $display("FAIL avg_full_map: got %0d bad outputs expected 0", bad); end
    endtask

    task automatic test_midrun_reset();
        int bc, bad, n_at, w0;
        bit hit = 0;
        w0 = wr_q_a.size();
        @(negedge clk); mode_a = 1'b0; ready_a = 1'b1;
        @(negedge clk); ready_a = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            if (wr_q_a.size() - w0 >= 100) hit = 1;
            else @(negedge clk);
        end
        checks++; if (!hit) begin errors++; $display("FAIL midrun_wait: got %0d writes expected 100", wr_q_a.size() - w0); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_at = wr_q_a.size();
        #1;
        checks++; if (cwr_a !== 1'b0 || crd_a !== 1'b0) begin errors++; $display("FAIL midrun_strobes: got cwr=%b crd=%b expected 0 0", cwr_a, crd_a); end
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midrun_busy: got %b expected 0", busy_a); end
        checks++; if (wr_q_a.size() !== n_at) begin errors++; $display("FAIL midrun_no_write: got %0d writes expected %0d", wr_q_a.size(), n_at); end
        reset = 1'b1;
        for (int i = 0; i < 4096; i++) src_a[i] = DW'($urandom);
        run_a(1'b0, 1'b0, bc);
        checks++; if (wr_q_a.size() - wb_a !== 1024) begin errors++; $display("FAIL restart_write_count: got %0d expected 1024", wr_q_a.size() - wb_a); end
        bad = map_bad_a(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL restart_full_map: got %0d bad outputs expected 0", bad); end
    endtask

    task automatic test_pool4();
        int bc, bad, rbad;
        for (int i = 0; i < 256; i++) src_b[i] = DW'($urandom);
        run_b(1'b0, bc);
        checks++; if (bc !== 288) begin errors++; $display("FAIL p4_busy_cycles: got %0d expected 288", bc); end
        checks++; if (wr_q_b.size() - wb_b !== 16) begin errors++; $display("FAIL p4_write_count: got %0d expected 16", wr_q_b.size() - wb_b); end
        rbad = 0;
        for (int j = 0; j < 16; j++)
            if (rd_q_b[rb_b + 16 + j] !== 16 * (j / 4) + 4 + j % 4) rbad++;
        checks++; if (rbad !== 0) begin errors++; $display("FAIL p4_output1_reads: got %0d wrong addresses expected 0", rbad); end
        checks++; if (wr_q_b[wb_b + 1] !== 1) begin errors++; $display("FAIL p4_output1_addr: got %0d expected 1", wr_q_b[wb_b + 1]); end
        checks++; if (wc_q_b[wb_b + 1] - wc_q_b[wb_b] !== 18) begin errors++; $display("FAIL p4_output_period: got %0d expected 18", wc_q_b[wb_b + 1] - wc_q_b[wb_b]); end
        bad = map_bad_b(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL p4_max_map: got %0d bad outputs expected 0", bad); end
        run_b(1'b1, bc);
        bad = map_bad_b(1'b1);
        checks++; if (bad !== 0) begin errors++; $display("FAIL p4_avg_map: got %0d bad outputs expected 0", bad); end
        checks++; if (csel_bad_b - cb_b !== 0 || overlap_b !== 0) begin
            errors++; $display("FAIL p4_csel_overlap: got csel_bad=%0d overlap=%0d expected 0 0", csel_bad_b - cb_b, overlap_b);
        end
    endtask

    initial begin
        test_reset();
        test_max_default();
        test_average();
        test_midrun_reset();
        test_pool4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
